// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops, iterative 1-bit-per-clock shifts,
// with a start/busy/done handshake and registered result/flags.
module alu_seq_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             sign,
    output logic             carry
);

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

    state_t           state, state_next;
    shkind_t          kind_in, kind;
    logic [SHAMT_W-1:0] k, count;
    logic             is_shift;
    logic [WIDTH-1:0] work, comb_res, step_res;
    logic             comb_carry, step_out;
    logic [WIDTH:0]   sum, diff;

    always_comb begin
        k        = b[SHAMT_W-1:0];
        is_shift = (alu_ctrl[2:0] == 3'b100) || (alu_ctrl[2:0] == 3'b101) ||
                   (alu_ctrl[2:0] == 3'b110);
        case (alu_ctrl[1:0])
            2'b00:   kind_in = SH_LL;
            2'b01:   kind_in = SH_RL;
            default: kind_in = SH_RA;
        endcase
        sum        = {1'b0, a} + {1'b0, b};
        diff       = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        comb_res   = '0;
        comb_carry = 1'b0;
        case (alu_ctrl)
            4'b0000, 4'b1000: begin
                comb_res   = sum[WIDTH-1:0];
                comb_carry = sum[WIDTH];
            end
            4'b0001, 4'b1001: comb_res = ~b + WIDTH'(1);
            4'b0010:          comb_res = a & b;
            4'b0011:          comb_res = a ^ b;
            4'b0111: begin
                comb_res   = diff[WIDTH-1:0];
                comb_carry = diff[WIDTH];
            end
            // Only reaches the result register for a zero shift amount.
            4'b0100, 4'b1100, 4'b0101, 4'b1101, 4'b0110, 4'b1110: comb_res = a;
            default: ;
        endcase
    end

    always_comb begin
        step_res = work;
        step_out = 1'b0;
        case (kind)
            SH_LL: begin
                step_res = {work[WIDTH-2:0], 1'b0};
                step_out = work[WIDTH-1];
            end
            SH_RL: begin
                step_res = {1'b0, work[WIDTH-1:1]};
                step_out = work[0];
            end
            default: begin
                step_res = {work[WIDTH-1], work[WIDTH-1:1]};
                step_out = work[0];
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && is_shift && k != '0) state_next = SHIFT;
            SHIFT:   if (count == SHAMT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
            sign   <= 1'b0;
            carry  <= 1'b0;
            count  <= '0;
            work   <= '0;
            kind   <= SH_LL;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_shift && k != '0) begin
                            work  <= a;
                            count <= k;
                            kind  <= kind_in;
                            busy  <= 1'b1;
                        end else begin
                            result <= comb_res;
                            carry  <= comb_carry;
                            zero   <= (comb_res == '0);
                            sign   <= comb_res[WIDTH-1];
                            done   <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work  <= step_res;
                    count <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) begin
                        result <= step_res;
                        carry  <= step_out;
                        zero   <= (step_res == '0);
                        sign   <= step_res[WIDTH-1];
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: driver pushes model results with their expected
// completion cycle; a negedge monitor pops and compares on every done pulse.
module tb_alu_seq_exec;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  a, b;
    logic          busy, done, zero, sign, carry;
    logic [W-1:0]  result;

    alu_seq_exec #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero), .sign(sign), .carry(carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         z, s, c;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   busy_until = 0;
    int   n_tests = 0, n_fail = 0;
    bit   mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain arithmetic on the operation's meaning.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [63:0] wide;
        int k;
        k = int'(y[4:0]);
        e.res = '0;
        e.c = 1'b0;
        case (op)
            4'b0000, 4'b1000: begin
                wide = 64'(x) + 64'(y);
                e.res = wide[W-1:0];
                e.c = wide[W];
            end
            4'b0001, 4'b1001: e.res = W'(0) - y;
            4'b0010: e.res = x & y;
            4'b0011: e.res = x ^ y;
            4'b0111: begin
                e.res = x - y;
                e.c = (x >= y);
            end
            4'b0100, 4'b1100: begin
                e.res = x << k;
                e.c = (k > 0) ? x[W-k] : 1'b0;
            end
            4'b0101, 4'b1101: begin
                e.res = x >> k;
                e.c = (k > 0) ? x[k-1] : 1'b0;
            end
            4'b0110, 4'b1110: begin
                e.res = $unsigned($signed(x) >>> k);
                e.c = (k > 0) ? x[k-1] : 1'b0;
            end
            default: ;
        endcase
        e.z = (e.res == 0);
        e.s = e.res[W-1];
        e.cyc = 0;
        return e;
    endfunction

    function automatic int lat(input logic [3:0] op, input logic [W-1:0] y);
        if (op[2:0] == 3'b100 || op[2:0] == 3'b101 || op[2:0] == 3'b110) return int'(y[4:0]);
        return 0;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one start pulse; model decides whether the DUT is free to accept it.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int c, k;
        alu_ctrl = op; a = x; b = y; start = 1'b1;
        @(posedge clk);
        c = cyc;
        if (c >= busy_until) begin
            k = lat(op, y);
            e = model(op, x, y);
            e.cyc = c + 1 + k;
            q.push_back(e);
            busy_until = c + 1 + k;
        end
        @(negedge clk);
        start = 1'b0;
        alu_ctrl = 4'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0) begin
            check("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(busy), 32'(cyc < busy_until));
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("result", result, e.res);
                    check("zero", 32'(zero), 32'(e.z));
                    check("sign", 32'(sign), 32'(e.s));
                    check("carry", 32'(carry), 32'(e.c));
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                check("missing_done", 32'(done), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [3:0] op;
        logic [W-1:0] x, y;
        rst = 1'b1; start = 1'b0; alu_ctrl = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_result", result, '0);
        check("rst_flags", {29'd0, zero, sign, carry}, '0);
        check("rst_busy_done", {30'd0, busy, done}, '0);
        rst = 1'b0;
        mon_en = 1'b1;

        issue(4'b0000, 32'hFFFF_FFFF, 32'd1);  drain();
        issue(4'b0111, 32'd5, 32'd7);          drain();
        issue(4'b1001, 32'd0, 32'd5);          drain();
        issue(4'b1110, 32'h8000_0000, 32'd4);  drain();
        issue(4'b0101, 32'h3, 32'd1);          drain();
        issue(4'b1100, 32'h1234, 32'hFFFF_FFE0); drain();
        issue(4'b1111, 32'h1234, 32'h5678);    drain();

        // Start pulses mid-shift must be ignored.
        issue(4'b1100, 32'd1, 32'd31);
        repeat (5) @(negedge clk);
        issue(4'b0000, 32'd9, 32'd9);
        repeat (10) @(negedge clk);
        issue(4'b0011, 32'hFF, 32'h0F);
        drain();

        // Back-to-back accepts in the done cycle.
        issue(4'b0010, 32'hF0F0, 32'hFF00);
        issue(4'b0011, 32'hAAAA, 32'h5555);
        issue(4'b0100, 32'h1, 32'd2);
        issue(4'b0000, 32'd1, 32'd2);
        drain();

        // Reset on step 3 of a 10-step shift: no completion, everything cleared.
        issue(4'b0101, 32'hDEAD_BEEF, 32'd10);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        q.delete();
        busy_until = 0;
        @(negedge clk);
        check("midrst_result", result, '0);
        check("midrst_flags", {29'd0, zero, sign, carry}, '0);
        check("midrst_busy_done", {30'd0, busy, done}, '0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue(4'b1111, 32'h1, 32'h1);
        drain();

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom);
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            if ($urandom_range(0, 7) == 0) x = '0;
            issue(op, x, y);
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage ALU, directly downstream of the ALU control decoder; consumes its 4-bit ALU_control_output code plus two register/immediate operands.
- Single-cycle for arithmetic/logic ops; shifts are iterative, 1 bit per clock.
- start/busy/done handshake toward the multi-cycle datapath controller; result and flags go to writeback and the branch unit.

Parameters:
WIDTH, 32, operand/result width
SHAMT_W, 5, shift-amount width taken from b[SHAMT_W-1:0]

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only when busy=0
alu_ctrl  input  4  operation code (ALU_control_output from decoder)
a  input  WIDTH  operand A / value to shift
b  input  WIDTH  operand B / shift amount in b[SHAMT_W-1:0]
busy  output  1  iterative shift in progress
done  output  1  one-cycle pulse: result/flags updated
result  output  WIDTH  registered result, held until next completion
zero  output  1  result==0
sign  output  1  result[WIDTH-1]
carry  output  1  carry/borrow/last shifted-out bit

Behaviour:
- Reset (rst=1 at clk edge): busy=0, done=0, result=0, zero=0, sign=0, carry=0, counter=0, FSM->IDLE. Reset mid-shift aborts the op; no done is issued.
- Op codes:
  - 0000, 1000 ADD: a+b, carry=carry-out.
  - 0001, 1001 COMP: ~b+1, carry=0.
  - 0010 AND: a&b.
  - 0011 XOR: a^b.
  - 0111 SUB: a+~b+1, carry=carry-out (1 = no borrow).
  - 1100, 0100 SHLL: logical left.
  - 1101, 0101 SHRL: logical right.
  - 1110, 0110 SHRA: arithmetic right.
  - Any other code: result=0, carry=0.
  - AND/XOR/unknown: carry=0.
- Shift amount k=b[SHAMT_W-1:0]; b upper bits ignored for shifts.
- FSM states IDLE, SHIFT.
- IDLE, start=1 at edge E0, non-shift op or k=0:
  - result/flags written at E0.
  - done=1 for the cycle after E0.
  - Remain IDLE, busy stays 0.
  - k=0 shift: result=a, carry=0.
- IDLE, start=1 at E0, shift op with k>0:
  - Latch a, op and k at E0; busy=1 from E0; ->SHIFT.
  - At each edge E1..Ek: shift working reg 1 bit, counter-1.
  - carry takes the bit shifted out.
  - SHRA: fill with the sign bit.
- Shift completion at Ek:
  - result/flags written; busy->0; done=1 for the cycle after Ek; ->IDLE.
  - Total latency k+1 edges.
  - Inputs may change after E0 without effect.
- start while busy=1: ignored, not queued. start in the cycle done=1 (busy=0): accepted, back-to-back allowed.
- zero and sign are registered alongside result and reflect the new result.
- Outputs hold their values between completions.
- Arithmetic is modulo 2^WIDTH; no overflow flag.

Test Plan:
- ADD a=0xFFFFFFFF, b=1, start 1 cycle -> done next cycle; result=0, zero=1, carry=1, sign=0, busy never 1.
- SUB a=5, b=7 (0111) -> result=0xFFFFFFFE, sign=1, carry=0. COMP b=5 (1001) -> result=0xFFFFFFFB.
- SHRA (1110) a=0x80000000, b=4 -> busy high 4 cycles; done after 5th edge; result=0xF8000000, carry=0.
- SHLL (1100) a=1, b=31 -> result=0x80000000 at latency 32. Pulse start with ADD mid-shift -> ignored, single done.
- SHRL (0101) a=0x3, b=1 -> result=1, carry=1. k=0 shift a=0x1234 -> result=0x1234 in 1 cycle.
- Assert rst at SHIFT step 3 of a k=10 shift -> next cycle all outputs 0, FSM IDLE, no done. Unknown code 1111 -> result=0, done 1 cycle later.
